// File: rtl/bram_write_sched_pkg.sv
// bram_wr_pkg: shared state encoding and default geometry for the BRAM write scheduler.
package bram_wr_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;
  localparam int NBANKS_DEF = 8;
  localparam int BANK_AW_DEF = 10;
  localparam int DW_DEF = 8;
  // Bank index sits directly above the in-bank address in the request address.
  localparam int BANK_W = 3;
  localparam int BANK_LSB_DEF = BANK_AW_DEF;
  localparam int BANK_MSB_DEF = BANK_AW_DEF + BANK_W - 1;
endpackage

// File: rtl/bram_write_sched_rr_arb2.sv
// rr_arb2: two-requester round-robin arbiter; a tie goes to the requester not granted last.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] valid,
  input  logic       advance,
  output logic [1:0] grant
);
  logic last_grant;
  always_ff @(posedge clk)
    if (reset) last_grant <= 1'b1;
    else if (advance) last_grant <= grant[1];
  assign grant = (valid == 2'b11) ? (last_grant ? 2'b01 : 2'b10) : valid;
endmodule

// File: rtl/bram_write_sched.sv
// bram_write_sched: arbitrates two byte writers onto the banked framebuffer BRAM write port.
// Define BRAM_WR_BLANK_ONLY_EN to accept new writes only during the blanking interval.
module bram_write_sched
  import bram_wr_pkg::*;
#(
  parameter int NBANKS = NBANKS_DEF,
  parameter int BANK_AW = BANK_AW_DEF,
  parameter int DW = DW_DEF,
  parameter int STROBE_CYCLES = 2,
  parameter int HOLD_CYCLES = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req0_valid,
  input  logic [BANK_AW+BANK_W-1:0] req0_addr,
  input  logic [DW-1:0]             req0_data,
  output logic                      req0_ready,
  input  logic                      req1_valid,
  input  logic [BANK_AW+BANK_W-1:0] req1_addr,
  input  logic [DW-1:0]             req1_data,
  output logic                      req1_ready,
  input  logic                      blank,
  output logic [BANK_AW-1:0]        wr_addr,
  output logic [DW-1:0]             wr_data,
  output logic [NBANKS-1:0]         wr_strobe,
  output logic                      busy
);
  localparam int CW = $clog2(STROBE_CYCLES > HOLD_CYCLES ? STROBE_CYCLES : HOLD_CYCLES) + 1;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [BANK_W-1:0] cap_bank;
  logic [1:0] eligible, grant;
  logic live, accept;
`ifdef BRAM_WR_BLANK_ONLY_EN
  assign eligible = {req1_valid, req0_valid} & {2{blank}};
`else
  logic unused_blank;
  assign unused_blank = blank;
  assign eligible = {req1_valid, req0_valid};
`endif
  rr_arb2 u_arb (
    .clk(clk),
    .reset(reset),
    .valid(eligible),
    .advance(accept),
    .grant(grant)
  );
  assign live = (state == IDLE) && !reset;
  assign accept = live && (|grant);
  assign {req1_ready, req0_ready} = grant & {2{live}};
  assign busy = state != IDLE;
  assign wr_strobe = (state == STROBE && 32'(cap_bank) < NBANKS) ?
                     {{(NBANKS-1){1'b0}}, 1'b1} << cap_bank : '0;
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    case (state)
      IDLE: state_n = accept ? SETUP : IDLE;
      SETUP: begin
        state_n = STROBE;
        cnt_n = CW'(STROBE_CYCLES - 1);
      end
      STROBE: begin
        state_n = (cnt == '0) ? HOLD : STROBE;
        cnt_n = (cnt == '0) ? CW'(HOLD_CYCLES - 1) : cnt - 1'b1;
      end
      HOLD: begin
        state_n = (cnt == '0) ? IDLE : HOLD;
        cnt_n = (cnt == '0) ? cnt : cnt - 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      cap_bank <= '0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      if (accept) begin
        {cap_bank, wr_addr} <= grant[1] ? req1_addr : req0_addr;
        wr_data <= grant[1] ? req1_data : req0_data;
      end
    end
endmodule

// File: tb/tb_bram_write_sched.sv
// tb_bram_write_sched: directed checks of handshake, arbitration, strobe timing and reset abort.
module tb_bram_write_sched;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic req0_valid = 1'b0, req1_valid = 1'b0;
  logic [12:0] req0_addr = '0, req1_addr = '0;
  logic [7:0] req0_data = '0, req1_data = '0;
  logic req0_ready, req1_ready;
  logic blank = 1'b0;
  logic [9:0] wr_addr;
  logic [7:0] wr_data;
  logic [7:0] wr_strobe;
  logic busy;
  int vectors = 0;
  int miscompares = 0;
  logic [1:0] exp_rdy;

  bram_write_sched dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
    .blank(blank), .wr_addr(wr_addr), .wr_data(wr_data), .wr_strobe(wr_strobe), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    req0_valid = 1'b1;
    step();
    #1;
    chk("rst_ready", 32'({req1_ready, req0_ready}), 32'd0);
    chk("rst_strobe", 32'(wr_strobe), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_addr", 32'(wr_addr), 32'd0);
    chk("rst_data", 32'(wr_data), 32'd0);
    step();
    reset = 1'b0;
    req0_addr = 13'h1405;
    req0_data = 8'hA5;
    #1;
    chk("t1_ready", 32'({req1_ready, req0_ready}), 32'd1);
    step();
    req0_valid = 1'b0;
    #1;
    chk("t1_setup_busy", 32'(busy), 32'd1);
    chk("t1_setup_strobe", 32'(wr_strobe), 32'd0);
    chk("t1_addr", 32'(wr_addr), 32'h005);
    chk("t1_data", 32'(wr_data), 32'hA5);
    step();
    #1;
    chk("t1_strobe_a", 32'(wr_strobe), 32'h20);
    step();
    #1;
    chk("t1_strobe_b", 32'(wr_strobe), 32'h20);
    step();
    #1;
    chk("t1_hold_strobe", 32'(wr_strobe), 32'd0);
    chk("t1_hold_addr", 32'(wr_addr), 32'h005);
    step();
    #1;
    chk("t1_hold_busy", 32'(busy), 32'd1);
    step();
    #1;
    chk("t1_idle_busy", 32'(busy), 32'd0);

    reset = 1'b1;
    step();
    reset = 1'b0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    req0_addr = 13'h0011;
    req1_addr = 13'h1C22;
    exp_rdy = 2'b01;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("rr_grant%0d", k), 32'({req1_ready, req0_ready}), 32'(exp_rdy));
      for (int c = 1; c < 6; c++) begin
        step();
        #1;
        chk($sformatf("rr_wait%0d_%0d", k, c), 32'({req1_ready, req0_ready}), 32'd0);
      end
      step();
      exp_rdy = ~exp_rdy;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    step();
    step();
    step();
    step();
    step();
    #1;
    chk("rr_last_data_bank", 32'(wr_addr), 32'h022);

    req0_valid = 1'b1;
    req0_addr = 13'h0C00;
    req0_data = 8'h3C;
    #1;
    chk("ab_ready", 32'(req0_ready), 32'd1);
    step();
    req0_valid = 1'b0;
    step();
    #1;
    chk("ab_strobe", 32'(wr_strobe), 32'h08);
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    chk("ab_strobe_off", 32'(wr_strobe), 32'd0);
    chk("ab_busy", 32'(busy), 32'd0);
    for (int c = 0; c < 3; c++) begin
      step();
      #1;
      chk($sformatf("ab_quiet%0d", c), 32'({busy, wr_strobe}), 32'd0);
    end

    for (int b = 0; b < 8; b++) begin
      req0_valid = 1'b1;
      req0_addr = {b[2:0], 10'h0FF};
      req0_data = 8'(b);
      #1;
      chk($sformatf("bank%0d_ready", b), 32'(req0_ready), 32'd1);
      step();
      req0_valid = 1'b0;
      step();
      #1;
      chk($sformatf("bank%0d_strobe", b), 32'(wr_strobe), 32'd1 << b);
      step();
      step();
      step();
      step();
    end

`ifdef BRAM_WR_BLANK_ONLY_EN
    blank = 1'b0;
    req0_valid = 1'b1;
    req0_addr = 13'h0805;
    req0_data = 8'h5A;
    #1;
    chk("blk_no_ready", 32'(req0_ready), 32'd0);
    step();
    #1;
    chk("blk_no_ready2", 32'({busy, req0_ready}), 32'd0);
    blank = 1'b1;
    #1;
    chk("blk_ready", 32'(req0_ready), 32'd1);
    step();
    req0_valid = 1'b0;
    step();
    blank = 1'b0;
    #1;
    chk("blk_strobe_a", 32'(wr_strobe), 32'h04);
    step();
    #1;
    chk("blk_strobe_b", 32'(wr_strobe), 32'h04);
    step();
    step();
    step();
    #1;
    chk("blk_idle", 32'(busy), 32'd0);
`else
    blank = 1'b0;
    req1_valid = 1'b1;
    req1_addr = 13'h0805;
    req1_data = 8'h5A;
    #1;
    chk("blk_ignored_ready", 32'({req1_ready, req0_ready}), 32'd2);
    step();
    req1_valid = 1'b0;
    step();
    #1;
    chk("blk_ignored_strobe", 32'(wr_strobe), 32'h04);
    chk("blk_ignored_data", 32'(wr_data), 32'h5A);
    step();
    step();
    step();
    step();
    #1;
    chk("blk_ignored_idle", 32'(busy), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
